// File: rtl/qu_common.sv
// rtl/qu_common.sv - shared issue-queue types and sizes
package qu_common;

    localparam int RES_ST_DEPTH      = 8;
    localparam int PHY_RF_ADDR_WIDTH = 6;
    localparam int UOP_WIDTH         = 8;

    typedef logic [$clog2(RES_ST_DEPTH)-1:0] res_st_addr_t;

    typedef struct packed {
        logic [UOP_WIDTH-1:0]         uop;
        logic [PHY_RF_ADDR_WIDTH-1:0] rd_phy;
        logic                         rs1_rdy;
        logic [PHY_RF_ADDR_WIDTH-1:0] rs1_tag;
        logic [31:0]                  rs1_val;
        logic                         rs2_rdy;
        logic [PHY_RF_ADDR_WIDTH-1:0] rs2_tag;
        logic [31:0]                  rs2_val;
    } res_st_cell_t;

endpackage

// File: rtl/res_station_prio_enc.sv
// rtl/res_station_prio_enc.sv - lowest-index priority encoder
module prio_enc #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_in,
    output logic [W-1:0] idx_out,
    output logic         found_out
);

    // Scanning high-to-low leaves the lowest set index as the final winner.
    always_comb begin
        idx_out   = '0;
        found_out = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_in[i]) begin
                idx_out   = W'(i);
                found_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/res_station.sv
// rtl/res_station.sv - reservation station with writeback wakeup and in-order-by-index issue
module res_station #(
    parameter int RES_ST_DEPTH      = qu_common::RES_ST_DEPTH,
    parameter int PHY_RF_ADDR_WIDTH = qu_common::PHY_RF_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         res_st_wr_en_in,
    input  qu_common::res_st_addr_t      res_st_wr_addr_in,
    input  qu_common::res_st_cell_t      res_st_data_in,
    output qu_common::res_st_addr_t      free_addr_out,
    output logic                         full_out,
    input  logic                         wb_en,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] wb_tag,
    input  logic [31:0]                  wb_data,
    output logic                         iss_valid_out,
    input  logic                         iss_ready_in,
    output qu_common::res_st_cell_t      iss_data_out,
    output logic                         wr_err_out
);
    import qu_common::*;

    localparam int AW = $clog2(RES_ST_DEPTH);

    logic [RES_ST_DEPTH-1:0] valid_q, valid_d;
    res_st_cell_t            cells_q [RES_ST_DEPTH];
    res_st_cell_t            cells_d [RES_ST_DEPTH];
    logic                    err_q, err_d;

    logic [RES_ST_DEPTH-1:0] ready_vec;
    logic [AW-1:0]           iss_idx;
    logic [AW-1:0]           free_idx;
    logic                    free_found;
    res_st_cell_t            wr_cell;

    always_comb begin
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            ready_vec[i] = valid_q[i] & cells_q[i].rs1_rdy & cells_q[i].rs2_rdy;
        end
    end

    prio_enc #(.N(RES_ST_DEPTH)) u_iss_sel (
        .req_in    (ready_vec),
        .idx_out   (iss_idx),
        .found_out (iss_valid_out)
    );

    prio_enc #(.N(RES_ST_DEPTH)) u_free_sel (
        .req_in    (~valid_q),
        .idx_out   (free_idx),
        .found_out (free_found)
    );

    assign full_out      = ~free_found;
    assign free_addr_out = free_found ? free_idx : '0;
    assign iss_data_out  = cells_q[iss_idx];
    assign wr_err_out    = err_q;

    // Incoming cell with same-cycle writeback folded in, so no wakeup is missed.
    always_comb begin
        wr_cell = res_st_data_in;
        if (wb_en && !wr_cell.rs1_rdy && wr_cell.rs1_tag == wb_tag) begin
            wr_cell.rs1_rdy = 1'b1;
            wr_cell.rs1_val = wb_data;
        end
        if (wb_en && !wr_cell.rs2_rdy && wr_cell.rs2_tag == wb_tag) begin
            wr_cell.rs2_rdy = 1'b1;
            wr_cell.rs2_val = wb_data;
        end
    end

    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            cells_d[i] = cells_q[i];
            if (wb_en && valid_q[i] && !cells_q[i].rs1_rdy && cells_q[i].rs1_tag == wb_tag) begin
                cells_d[i].rs1_rdy = 1'b1;
                cells_d[i].rs1_val = wb_data;
            end
            if (wb_en && valid_q[i] && !cells_q[i].rs2_rdy && cells_q[i].rs2_tag == wb_tag) begin
                cells_d[i].rs2_rdy = 1'b1;
                cells_d[i].rs2_val = wb_data;
            end
        end
        if (iss_valid_out && iss_ready_in) begin
            valid_d[iss_idx] = 1'b0;
        end
        if (flush) begin
            valid_d = '0;
        end else if (res_st_wr_en_in) begin
            if (valid_q[res_st_wr_addr_in]) begin
                err_d = 1'b1;
            end else begin
                cells_d[res_st_wr_addr_in] = wr_cell;
                valid_d[res_st_wr_addr_in] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
        end
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            cells_q[i] <= cells_d[i];
        end
    end

endmodule

// File: tb/tb_res_station.sv
// tb/tb_res_station.sv - randomized and directed bench with a behavioural reservation-station model
module tb_res_station;
    import qu_common::*;

    logic         clk = 1'b0;
    logic         rst, flush, wr_en, wb_en, iss_ready;
    res_st_addr_t wr_addr, free_addr;
    res_st_cell_t wr_data, iss_data;
    logic [5:0]   wb_tag;
    logic [31:0]  wb_data;
    logic         full, iss_valid, wr_err;

    int checks = 0;
    int errors = 0;

    logic         m_valid [8];
    res_st_cell_t m_cell  [8];
    logic         m_err;

    res_station dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .res_st_wr_en_in   (wr_en),
        .res_st_wr_addr_in (wr_addr),
        .res_st_data_in    (wr_data),
        .free_addr_out     (free_addr),
        .full_out          (full),
        .wb_en             (wb_en),
        .wb_tag            (wb_tag),
        .wb_data           (wb_data),
        .iss_valid_out     (iss_valid),
        .iss_ready_in      (iss_ready),
        .iss_data_out      (iss_data),
        .wr_err_out        (wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int m_iss_idx();
        for (int i = 0; i < 8; i++)
            if (m_valid[i] && m_cell[i].rs1_rdy && m_cell[i].rs2_rdy) return i;
        return -1;
    endfunction

    function automatic int m_free_idx();
        for (int i = 0; i < 8; i++)
            if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic res_st_cell_t wake(input res_st_cell_t c);
        res_st_cell_t r = c;
        if (wb_en && !r.rs1_rdy && r.rs1_tag == wb_tag) begin r.rs1_rdy = 1'b1; r.rs1_val = wb_data; end
        if (wb_en && !r.rs2_rdy && r.rs2_tag == wb_tag) begin r.rs2_rdy = 1'b1; r.rs2_val = wb_data; end
        return r;
    endfunction

    task automatic model_update();
        logic         nv [8];
        res_st_cell_t nc [8];
        int           iss = m_iss_idx();
        if (rst) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            m_err = 1'b0;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            nv[i] = m_valid[i];
            nc[i] = m_valid[i] ? wake(m_cell[i]) : m_cell[i];
        end
        if (iss >= 0 && iss_ready) nv[iss] = 1'b0;
        if (!flush && wr_en) begin
            if (m_valid[int'(wr_addr)]) m_err = 1'b1;
            else begin
                nv[int'(wr_addr)] = 1'b1;
                nc[int'(wr_addr)] = wake(wr_data);
            end
        end
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = flush ? 1'b0 : nv[i];
            m_cell[i]  = nc[i];
        end
    endtask

    task automatic check_outputs();
        int ii = m_iss_idx();
        int fi = m_free_idx();
        chk("iss_valid", iss_valid, ii >= 0);
        if (ii >= 0) chk("iss_data", iss_data, m_cell[ii]);
        chk("full", full, fi < 0);
        chk("free_addr", free_addr, (fi < 0) ? 0 : fi);
        chk("wr_err", wr_err, m_err);
    endtask

    task automatic cycle();
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; flush = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
        wb_en = 0; wb_tag = '0; wb_data = '0; iss_ready = 0;
    endtask

    function automatic res_st_cell_t mk(input logic [7:0] uop, input logic r1, input logic [5:0] t1,
                                        input logic r2, input logic [5:0] t2);
        res_st_cell_t c;
        c.uop = uop; c.rd_phy = uop[5:0];
        c.rs1_rdy = r1; c.rs1_tag = t1; c.rs1_val = r1 ? {24'h0, uop} : 32'h0;
        c.rs2_rdy = r2; c.rs2_tag = t2; c.rs2_val = r2 ? {24'h1, uop} : 32'h0;
        return c;
    endfunction

    task automatic write(input int a, input res_st_cell_t c);
        wr_en = 1; wr_addr = res_st_addr_t'(a); wr_data = c;
    endtask

    initial begin
        res_st_cell_t cell_a;
        for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_cell[i] = '0; end
        m_err = 1'b0;
        idle();
        @(negedge clk);
        rst = 1; cycle(); rst = 0;
        chk("rst_iss_valid", iss_valid, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_free", free_addr, 3'd0);

        // ready entry 2 issues the cycle after the write
        write(2, mk(8'h22, 1, 6'd1, 1, 6'd2)); iss_ready = 1; cycle(); idle(); iss_ready = 1;
        chk("t34_iss_valid", iss_valid, 1'b1);
        chk("t34_uop", iss_data.uop, 8'h22);
        cycle(); idle();
        chk("t34_freed", iss_valid, 1'b0);
        cycle();

        // wakeup by writeback
        write(0, mk(8'h30, 0, 6'd5, 1, 6'd0)); cycle(); idle();
        chk("t35_waiting", iss_valid, 1'b0);
        wb_en = 1; wb_tag = 6'd5; wb_data = 32'hDEADBEEF; cycle(); idle();
        chk("t35_iss_valid", iss_valid, 1'b1);
        chk("t35_rs1_val", iss_data.rs1_val, 32'hDEADBEEF);
        iss_ready = 1; cycle(); idle();

        // bypass of a same-cycle writeback into the write
        write(1, mk(8'h36, 1, 6'd0, 0, 6'd7)); wb_en = 1; wb_tag = 6'd7; wb_data = 32'h1234; cycle(); idle();
        chk("t36_iss_valid", iss_valid, 1'b1);
        chk("t36_rs2_val", iss_data.rs2_val, 32'h1234);
        iss_ready = 1; cycle(); idle();

        // fill all entries, then free one
        for (int i = 0; i < 8; i++) begin
            write(i, mk(8'h40 + 8'(i), 0, 6'(10 + i), 1, 6'd0)); cycle(); idle();
        end
        chk("t37_full", full, 1'b1);
        chk("t37_free_zero", free_addr, 3'd0);
        wb_en = 1; wb_tag = 6'd15; wb_data = 32'h55; cycle(); idle();
        iss_ready = 1; cycle(); idle();
        chk("t37_not_full", full, 1'b0);
        chk("t37_free_idx", free_addr, 3'd5);
        flush = 1; cycle(); idle();

        // write to an occupied entry is dropped and flagged
        cell_a = mk(8'h3A, 1, 6'd0, 1, 6'd0);
        write(3, cell_a); cycle(); idle();
        write(3, mk(8'h3B, 1, 6'd1, 1, 6'd1)); cycle(); idle();
        chk("t38_err", wr_err, 1'b1);
        chk("t38_unchanged", iss_data, cell_a);
        cycle(); cycle();
        chk("t38_err_sticky", wr_err, 1'b1);

        // flush then reset mid-stream with the execution unit stalled
        write(4, mk(8'h44, 1, 6'd0, 1, 6'd0)); cycle(); idle();
        flush = 1;
        chk("t39_flush_cycle_valid", iss_valid, 1'b1);
        write(6, mk(8'h66, 1, 6'd0, 1, 6'd0)); cycle(); idle();
        chk("t39_flush_cleared", iss_valid, 1'b0);
        chk("t39_flush_free", free_addr, 3'd0);
        write(0, mk(8'h50, 1, 6'd0, 1, 6'd0)); cycle(); idle();
        write(1, mk(8'h51, 0, 6'd3, 1, 6'd0)); cycle(); idle();
        rst = 1; flush = 1; wb_en = 1; wb_tag = 6'd3;
        write(2, mk(8'h52, 1, 6'd0, 1, 6'd0)); cycle(); idle();
        chk("t39_rst_valid", iss_valid, 1'b0);
        chk("t39_rst_err", wr_err, 1'b0);
        chk("t39_rst_full", full, 1'b0);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int fi = m_free_idx();
            idle();
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1) == 1) begin
                write((fi < 0 || $urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : fi,
                      mk(8'($urandom), 1'($urandom), 6'($urandom_range(0, 7)),
                         1'($urandom), 6'($urandom_range(0, 7))));
            end
            wb_en     = ($urandom_range(0, 2) != 0);
            wb_tag    = 6'($urandom_range(0, 7));
            wb_data   = $urandom;
            iss_ready = ($urandom_range(0, 2) == 0);
            cycle();
        end
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
